// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display driver.
//   NUM_DIGITS  - digits on the display
//   SEG_BLANK   - all segments off (active-low)
//   HEX_*       - active-low patterns for hex glyphs 0..F
//   seg_bit_e   - bit position of each segment in the {g,f,e,d,c,b,a} vector
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

endpackage

// File: rtl/seg_display_driver_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment pattern.
//   nibble_i [3:0] - hex value
//   seg_o    [6:0] - cathodes {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = HEX_0;
            4'h1: seg_o = HEX_1;
            4'h2: seg_o = HEX_2;
            4'h3: seg_o = HEX_3;
            4'h4: seg_o = HEX_4;
            4'h5: seg_o = HEX_5;
            4'h6: seg_o = HEX_6;
            4'h7: seg_o = HEX_7;
            4'h8: seg_o = HEX_8;
            4'h9: seg_o = HEX_9;
            4'hA: seg_o = HEX_A;
            4'hB: seg_o = HEX_B;
            4'hC: seg_o = HEX_C;
            4'hD: seg_o = HEX_D;
            4'hE: seg_o = HEX_E;
            4'hF: seg_o = HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: time-multiplexed driver for an eight-digit common-anode
// seven-segment display. The 32-bit word is latched once per frame (at the end
// of digit 7's slot, unless freeze_i is high) so the display never tears.
//   clk_i        - system clock, rising edge
//   rst_i        - synchronous active-high reset
//   data_i[31:0] - word to display, nibble i -> digit i (digit 0 rightmost)
//   dp_en_i[7:0] - per-digit decimal point enable, latched with data_i
//   freeze_i     - suppresses the end-of-frame capture
//   an_o[7:0]    - anode enables, active-low
//   seg_o[6:0]   - cathodes {g,f,e,d,c,b,a}, active-low
//   dp_o         - decimal-point cathode, active-low
// Build option: define SEG_LZB_EN for leading-zero blanking.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             data_i,
    input  logic [NUM_DIGITS-1:0]   dp_en_i,
    input  logic                    freeze_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              dig_q, dig_d;
    logic [31:0]             shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;

    logic       slot_end;
    logic       blank_win;
    logic       lz_blank;
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;

    assign slot_end = (cnt_q == CW'(DIGIT_CYCLES - 1));

    always_comb begin
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        dig_d       = slot_end ? dig_q + 3'd1 : dig_q;
        shadow_d    = shadow_q;
        dp_shadow_d = dp_shadow_q;
        if (slot_end && (dig_q == 3'd7) && !freeze_i) begin
            shadow_d    = data_i;
            dp_shadow_d = dp_en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            dig_q       <= '0;
            shadow_q    <= '0;
            dp_shadow_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
        end
    end

    assign blank_win  = (cnt_q < CW'(BLANK_CYCLES));
    assign cur_nibble = shadow_q[{dig_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

`ifdef SEG_LZB_EN
    // Highest nonzero nibble; digit 0 is the floor so an all-zero word shows "0".
    logic [2:0] top_nz;

    always_comb begin
        top_nz = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
        end
    end

    // A set decimal point keeps an otherwise-leading-zero digit visible.
    assign lz_blank = (dig_q > top_nz) && !dp_shadow_q[dig_q];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_o  = '1;
        seg_o = SEG_BLANK;
        dp_o  = 1'b1;
        if (!blank_win && !lz_blank) begin
            an_o  = ~(NUM_DIGITS'(1) << dig_q);
            seg_o = cur_seg;
            dp_o  = ~dp_shadow_q[dig_q];
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

    localparam int DC = 4;
    localparam int BC = 1;
    localparam int FRAME = 8 * DC;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp_en = '0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad = 0;

    // Model state: cycles since reset and the currently displayed image.
    int          m_t = 0;
    logic [31:0] m_sh = '0;
    logic [7:0]  m_dps = '0;
    bit          m_valid = 0;

    seg_display_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (data),
        .dp_en_i  (dp_en),
        .freeze_i (freeze),
        .an_o     (an),
        .seg_o    (seg),
        .dp_o     (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, m_t, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_out(input int pos, input logic [31:0] sh, input logic [7:0] dps);
        int slot;
        int ph;
        int hi;
        logic [3:0] nib;
        slot = (pos / DC) % 8;
        ph   = pos % DC;
        hi   = 0;
        for (int i = 0; i < 8; i++)
            if (((sh >> (4 * i)) & 32'hF) != 0) hi = i;
        nib = 4'((sh >> (4 * slot)) & 32'hF);
        if (ph < BC) return {8'hFF, 7'h7F, 1'b1};
`ifdef SEG_LZB_EN
        if (slot > hi && !dps[slot]) return {8'hFF, 7'h7F, 1'b1};
`endif
        return {~(8'd1 << slot), HEX[nib], ~dps[slot]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0;
            m_sh = '0;
            m_dps = '0;
            m_valid = 1;
        end else if (m_valid) begin
            if ((m_t % FRAME) == FRAME - 1 && !freeze) begin
                m_sh = data;
                m_dps = dp_en;
            end
            m_t = m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (m_valid) begin
            e = exp_out(m_t, m_sh, m_dps);
            chk("model_out", {16'h0, an, seg, dp}, {16'h0, e});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int target);
        int guard;
        guard = 0;
        while (m_t != target && guard < 1000) begin
            step(1);
            guard++;
        end
        if (m_t != target) begin
            bad++;
            $display("FAIL goto actual=%0d required=%0d", m_t, target);
        end
    endtask

    initial begin
        logic [6:0] scan_exp [8];
        scan_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

        // Reset with all-ones data: display blank, first frame all zeros.
        data = 32'hFFFFFFFF;
        step(1);
        rst = 1;
        step(2);
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dp}, 32'h1);
        rst = 0;
        data = 32'h76543210;
        step(1);
        chk("f0_an", {24'h0, an}, 32'hFE);
        chk("f0_seg", {25'h0, seg}, 32'h40);

        // Scan order in the second frame.
        goto(FRAME);
        chk("scan_blank", {24'h0, an}, 32'hFF);
        for (int k = 0; k < 8; k++) begin
            goto(FRAME + DC * k + 1);
            chk("scan_an", {24'h0, an}, {24'h0, ~(8'd1 << k)});
            chk("scan_seg", {25'h0, seg}, {25'h0, scan_exp[k]});
        end

        // Freeze holds the captured image over three frames.
        data = 32'h00000001;
        goto(2 * FRAME + 1);
        data = 32'hFFFFFFFF;
        freeze = 1;
        for (int f = 3; f < 6; f++) begin
            goto(f * FRAME + 1);
            chk("frz_d0", {25'h0, seg}, 32'h79);
            goto(f * FRAME + 3 * DC + 1);
`ifdef SEG_LZB_EN
            chk("frz_d3_an", {24'h0, an}, 32'hFF);
`else
            chk("frz_d3_seg", {25'h0, seg}, 32'h40);
`endif
        end
        freeze = 0;
        goto(6 * FRAME + 1);
        chk("unfrz_d0", {25'h0, seg}, 32'h0E);
        goto(6 * FRAME + 7 * DC + 1);
        chk("unfrz_d7", {25'h0, seg}, 32'h0E);

        // Decimal point on digit 2 only.
        data = 32'h12345678;
        dp_en = 8'h04;
        goto(7 * FRAME + 2 * DC);
        chk("dp_blank", {31'h0, dp}, 32'h1);
        step(1);
        chk("dp_d2", {31'h0, dp}, 32'h0);
        goto(7 * FRAME + 3 * DC + 1);
        chk("dp_d3", {31'h0, dp}, 32'h1);

        // Reset mid-frame at digit 5, count 2.
        goto(7 * FRAME + 5 * DC + 2);
        rst = 1;
        step(1);
        rst = 0;
        chk("mid_rst_an", {24'h0, an}, 32'hFF);
        chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
        dp_en = 8'h00;
        data = 32'h000000A8;
        step(1);
        chk("mid_rst_zero", {25'h0, seg}, 32'h40);
        goto(2 * DC + 1);
        chk("mid_rst_nodp", {31'h0, dp}, 32'h1);

        // Leading-zero behaviour.
        goto(FRAME + 1);
        chk("lz_d0", {25'h0, seg}, 32'h00);
        goto(FRAME + DC + 1);
        chk("lz_d1", {25'h0, seg}, 32'h08);
        goto(FRAME + 2 * DC + 1);
`ifdef SEG_LZB_EN
        chk("lz_d2_an", {24'h0, an}, 32'hFF);
`else
        chk("lz_d2_an", {24'h0, an}, 32'hFB);
`endif
        data = 32'h0;
        goto(2 * FRAME + 1);
        chk("z_d0", {24'h0, an, 1'b0, seg}, {24'h0, 8'hFE, 8'h40});
        goto(2 * FRAME + DC + 1);
`ifdef SEG_LZB_EN
        chk("z_d1_an", {24'h0, an}, 32'hFF);
`else
        chk("z_d1_an", {24'h0, an}, 32'hFD);
`endif

        // Randomized traffic with occasional freeze and reset.
        for (int i = 0; i < 4000; i++) begin
            data   = $urandom;
            dp_en  = 8'($urandom);
            freeze = ($urandom_range(3) == 0);
            rst    = ($urandom_range(399) == 0);
            step(1);
        end
        rst = 0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
